// File: rtl/dcache_port_unit.sv
// dcache_port_unit: issues tagged load reads, tracks them until their responses return, and drains
// committed stores to the data cache in FIFO order. Define STORE_FWD_EN for store-to-load forwarding.
module dcache_port_unit #(
  parameter int LQ_ENTRIES = 8,
  parameter int SQ_DEPTH   = 4,
  localparam int LQW = $clog2(LQ_ENTRIES),
  localparam int SQW = $clog2(SQ_DEPTH)
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           ld_req_valid,
  output logic           ld_req_ready,
  input  logic [LQW-1:0] ld_req_LQ_index,
  input  logic [13:0]    ld_req_addr,
  output logic           ld_done_valid,
  output logic [LQW-1:0] ld_done_LQ_index,
  output logic [31:0]    ld_done_data,
  output logic           ld_done_inv,
  input  logic           st_commit_valid,
  output logic           st_commit_ready,
  input  logic [13:0]    st_commit_addr,
  input  logic [31:0]    st_commit_data,
  output logic           dcache_read_req_valid,
  output logic [LQW-1:0] dcache_read_req_LQ_index,
  output logic [13:0]    dcache_read_req_addr,
  input  logic           dcache_read_req_blocked,
  input  logic           dcache_read_resp_valid,
  input  logic [LQW-1:0] dcache_read_resp_LQ_index,
  input  logic [31:0]    dcache_read_resp_data,
  output logic           dcache_write_req_valid,
  output logic [13:0]    dcache_write_req_addr,
  output logic [31:0]    dcache_write_req_data,
  input  logic           dcache_write_req_blocked,
  input  logic           dcache_inv_valid,
  input  logic [12:0]    dcache_inv_block_addr,
  output logic           sq_empty,
  output logic           protocol_error
);

  logic [LQ_ENTRIES-1:0] tbl_valid;
  logic [LQ_ENTRIES-1:0] tbl_inv;
  logic [LQ_ENTRIES-1:0] inv_hit;
  logic [12:0]           tbl_blk [LQ_ENTRIES];

  logic [SQW:0]          head;
  logic [SQW:0]          tail;
  logic [SQW-1:0]        head_slot;
  logic [SQW-1:0]        tail_slot;
  logic [SQ_DEPTH-1:0]   sq_vld;
  logic [13:0]           sq_addr [SQ_DEPTH];
  logic [31:0]           sq_data [SQ_DEPTH];

  logic sq_full;
  logic enq;
  logic deq;
  logic buf_match;
  logic ld_accept;
  logic issue;
  logic resp_hit;
  logic dup_load;

  assign head_slot       = head[SQW-1:0];
  assign tail_slot       = tail[SQW-1:0];
  assign sq_empty        = (head == tail);
  assign sq_full         = (head_slot == tail_slot) && (head[SQW] != tail[SQW]);
  assign st_commit_ready = ~sq_full;
  assign enq             = st_commit_valid & ~sq_full;
  assign deq             = ~sq_empty & ~dcache_write_req_blocked;

  assign dcache_write_req_valid = ~sq_empty;
  assign dcache_write_req_addr  = sq_empty ? 14'd0 : sq_addr[head_slot];
  assign dcache_write_req_data  = sq_empty ? 32'd0 : sq_data[head_slot];

`ifdef STORE_FWD_EN
  logic           fwd_valid;
  logic [LQW-1:0] fwd_idx;
  logic [31:0]    fwd_data;
  logic [31:0]    fwd_sel_data;
  logic [SQW-1:0] slot;

  // Walk the buffer oldest to youngest so the last hit is the youngest store; a same-cycle commit is younger still.
  always_comb begin
    buf_match    = 1'b0;
    fwd_sel_data = 32'd0;
    slot         = head_slot;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      slot = head_slot + SQW'(k);
      if (sq_vld[slot] && (sq_addr[slot] == ld_req_addr)) begin
        buf_match    = 1'b1;
        fwd_sel_data = sq_data[slot];
      end
    end
    if (enq && (st_commit_addr == ld_req_addr)) begin
      buf_match    = 1'b1;
      fwd_sel_data = st_commit_data;
    end
  end

  assign ld_req_ready = ~nRST & ~dcache_read_req_blocked & ~fwd_valid;
  assign issue        = ld_accept & ~buf_match;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      fwd_valid <= 1'b0;
      fwd_idx   <= '0;
      fwd_data  <= 32'd0;
    end else if (ld_accept && buf_match) begin
      fwd_valid <= 1'b1;
      fwd_idx   <= ld_req_LQ_index;
      fwd_data  <= fwd_sel_data;
    end else if (fwd_valid && !resp_hit) begin
      fwd_valid <= 1'b0;
    end
  end
`else
  // Any buffered or same-cycle store to the load address holds the load off until it has drained.
  always_comb begin
    buf_match = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (sq_vld[i] && (sq_addr[i] == ld_req_addr)) begin
        buf_match = 1'b1;
      end
    end
    if (enq && (st_commit_addr == ld_req_addr)) begin
      buf_match = 1'b1;
    end
  end

  assign ld_req_ready = ~nRST & ~dcache_read_req_blocked & ~buf_match;
  assign issue        = ld_accept;
`endif

  assign ld_accept = ld_req_valid & ld_req_ready;
  assign resp_hit  = dcache_read_resp_valid & tbl_valid[dcache_read_resp_LQ_index];
  assign dup_load  = ld_accept & tbl_valid[ld_req_LQ_index] &
                     ~(resp_hit & (dcache_read_resp_LQ_index == ld_req_LQ_index));

  assign dcache_read_req_valid    = issue;
  assign dcache_read_req_LQ_index = issue ? ld_req_LQ_index : '0;
  assign dcache_read_req_addr     = issue ? ld_req_addr : 14'd0;

  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < LQ_ENTRIES; i++) begin
      inv_hit[i] = dcache_inv_valid & tbl_valid[i] & (tbl_blk[i] == dcache_inv_block_addr);
    end
  end

  // A cache response always wins the completion port; a forwarded result waits behind it.
  always_comb begin
    ld_done_valid    = 1'b0;
    ld_done_LQ_index = '0;
    ld_done_data     = 32'd0;
    ld_done_inv      = 1'b0;
    if (resp_hit) begin
      ld_done_valid    = 1'b1;
      ld_done_LQ_index = dcache_read_resp_LQ_index;
      ld_done_data     = dcache_read_resp_data;
      ld_done_inv      = tbl_inv[dcache_read_resp_LQ_index] | inv_hit[dcache_read_resp_LQ_index];
    end
`ifdef STORE_FWD_EN
    else if (fwd_valid) begin
      ld_done_valid    = 1'b1;
      ld_done_LQ_index = fwd_idx;
      ld_done_data     = fwd_data;
    end
`endif
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      tbl_valid <= '0;
      tbl_inv   <= '0;
      for (int i = 0; i < LQ_ENTRIES; i++) begin
        tbl_blk[i] <= 13'd0;
      end
    end else begin
      for (int i = 0; i < LQ_ENTRIES; i++) begin
        if (issue && (ld_req_LQ_index == LQW'(i))) begin
          tbl_valid[i] <= 1'b1;
          tbl_blk[i]   <= ld_req_addr[13:1];
          tbl_inv[i]   <= 1'b0;
        end else if (resp_hit && (dcache_read_resp_LQ_index == LQW'(i))) begin
          tbl_valid[i] <= 1'b0;
          tbl_inv[i]   <= 1'b0;
        end else if (inv_hit[i]) begin
          tbl_inv[i]   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      protocol_error <= 1'b0;
    end else if (dup_load || (dcache_read_resp_valid && !resp_hit)) begin
      protocol_error <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      head   <= '0;
      tail   <= '0;
      sq_vld <= '0;
    end else begin
      if (enq) begin
        sq_vld[tail_slot] <= 1'b1;
        tail              <= tail + 1'b1;
      end
      if (deq) begin
        sq_vld[head_slot] <= 1'b0;
        head              <= head + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      sq_addr[tail_slot] <= st_commit_addr;
      sq_data[tail_slot] <= st_commit_data;
    end
  end

endmodule

// File: tb/tb_dcache_port_unit.sv
// Testbench for dcache_port_unit: directed cases plus randomized traffic checked every cycle
// against a queue/array model of the load table and store buffer.
`timescale 1ns/1ps
module tb_dcache_port_unit;

  localparam int LQ  = 8;
  localparam int SQD = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ld_req_valid, ld_req_ready;
  logic [2:0]  ld_req_LQ_index;
  logic [13:0] ld_req_addr;
  logic        ld_done_valid;
  logic [2:0]  ld_done_LQ_index;
  logic [31:0] ld_done_data;
  logic        ld_done_inv;
  logic        st_commit_valid, st_commit_ready;
  logic [13:0] st_commit_addr;
  logic [31:0] st_commit_data;
  logic        dcache_read_req_valid;
  logic [2:0]  dcache_read_req_LQ_index;
  logic [13:0] dcache_read_req_addr;
  logic        dcache_read_req_blocked;
  logic        dcache_read_resp_valid;
  logic [2:0]  dcache_read_resp_LQ_index;
  logic [31:0] dcache_read_resp_data;
  logic        dcache_write_req_valid;
  logic [13:0] dcache_write_req_addr;
  logic [31:0] dcache_write_req_data;
  logic        dcache_write_req_blocked;
  logic        dcache_inv_valid;
  logic [12:0] dcache_inv_block_addr;
  logic        sq_empty, protocol_error;

  dcache_port_unit #(.LQ_ENTRIES(LQ), .SQ_DEPTH(SQD)) dut (
    .CLK(CLK), .nRST(nRST),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_LQ_index(ld_req_LQ_index), .ld_req_addr(ld_req_addr),
    .ld_done_valid(ld_done_valid), .ld_done_LQ_index(ld_done_LQ_index),
    .ld_done_data(ld_done_data), .ld_done_inv(ld_done_inv),
    .st_commit_valid(st_commit_valid), .st_commit_ready(st_commit_ready),
    .st_commit_addr(st_commit_addr), .st_commit_data(st_commit_data),
    .dcache_read_req_valid(dcache_read_req_valid),
    .dcache_read_req_LQ_index(dcache_read_req_LQ_index),
    .dcache_read_req_addr(dcache_read_req_addr),
    .dcache_read_req_blocked(dcache_read_req_blocked),
    .dcache_read_resp_valid(dcache_read_resp_valid),
    .dcache_read_resp_LQ_index(dcache_read_resp_LQ_index),
    .dcache_read_resp_data(dcache_read_resp_data),
    .dcache_write_req_valid(dcache_write_req_valid),
    .dcache_write_req_addr(dcache_write_req_addr),
    .dcache_write_req_data(dcache_write_req_data),
    .dcache_write_req_blocked(dcache_write_req_blocked),
    .dcache_inv_valid(dcache_inv_valid), .dcache_inv_block_addr(dcache_inv_block_addr),
    .sq_empty(sq_empty), .protocol_error(protocol_error)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ld_valid;
    logic [2:0]  ld_idx;
    logic [13:0] ld_addr;
    logic        st_valid;
    logic [13:0] st_addr;
    logic [31:0] st_data;
    logic        rd_blocked;
    logic        resp_valid;
    logic [2:0]  resp_idx;
    logic [31:0] resp_data;
    logic        wr_blocked;
    logic        inv_valid;
    logic [12:0] inv_blk;
  } stim_t;

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
  } store_t;

  int errors = 0;
  int checks = 0;

  bit          m_valid [LQ];
  logic [13:0] m_addr  [LQ];
  bit          m_inv   [LQ];
  store_t      m_sq[$];
  bit          m_perr;
  bit          m_fwd_valid;
  logic [2:0]  m_fwd_idx;
  logic [31:0] m_fwd_data;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setInputs(input stim_t s);
    ld_req_valid              = s.ld_valid;
    ld_req_LQ_index           = s.ld_idx;
    ld_req_addr               = s.ld_addr;
    st_commit_valid           = s.st_valid;
    st_commit_addr            = s.st_addr;
    st_commit_data            = s.st_data;
    dcache_read_req_blocked   = s.rd_blocked;
    dcache_read_resp_valid    = s.resp_valid;
    dcache_read_resp_LQ_index = s.resp_idx;
    dcache_read_resp_data     = s.resp_data;
    dcache_write_req_blocked  = s.wr_blocked;
    dcache_inv_valid          = s.inv_valid;
    dcache_inv_block_addr     = s.inv_blk;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge CLK);
    #1;
    setInputs(s);
  endtask

  // Reference model: outputs of the current cycle come from model state plus live inputs, then the state advances.
  always @(negedge CLK) begin : compare_model
    bit          full, enq, match, fhit, acc, rd_v, rhit, dup, e_inv;
    logic [31:0] fdata;
    if (nRST) begin
      checkOutput("rst_ld_req_ready", ld_req_ready, 0);
      checkOutput("rst_ld_done_valid", ld_done_valid, 0);
      checkOutput("rst_read_req_valid", dcache_read_req_valid, 0);
      checkOutput("rst_write_req_valid", dcache_write_req_valid, 0);
      checkOutput("rst_st_commit_ready", st_commit_ready, 1);
      checkOutput("rst_sq_empty", sq_empty, 1);
      checkOutput("rst_protocol_error", protocol_error, 0);
      for (int i = 0; i < LQ; i++) begin
        m_valid[i] = 0;
        m_inv[i]   = 0;
      end
      m_sq.delete();
      m_perr      = 0;
      m_fwd_valid = 0;
    end else begin
      full  = (m_sq.size() == SQD);
      enq   = st_commit_valid && !full;
      match = 0;
      fdata = '0;
      foreach (m_sq[k]) if (m_sq[k].addr == ld_req_addr) begin match = 1; fdata = m_sq[k].data; end
      if (enq && st_commit_addr == ld_req_addr) begin match = 1; fdata = st_commit_data; end
`ifdef STORE_FWD_EN
      fhit = match;
      acc  = ld_req_valid && !dcache_read_req_blocked && !m_fwd_valid;
      checkOutput("ld_req_ready", ld_req_ready, !dcache_read_req_blocked && !m_fwd_valid);
`else
      fhit = 0;
      acc  = ld_req_valid && !dcache_read_req_blocked && !match;
      checkOutput("ld_req_ready", ld_req_ready, !dcache_read_req_blocked && !match);
`endif
      rd_v = acc && !fhit;
      rhit = dcache_read_resp_valid && m_valid[dcache_read_resp_LQ_index];
      checkOutput("read_req_valid", dcache_read_req_valid, rd_v);
      if (rd_v) begin
        checkOutput("read_req_idx", dcache_read_req_LQ_index, ld_req_LQ_index);
        checkOutput("read_req_addr", dcache_read_req_addr, ld_req_addr);
      end
      checkOutput("st_commit_ready", st_commit_ready, !full);
      checkOutput("sq_empty", sq_empty, m_sq.size() == 0);
      checkOutput("write_req_valid", dcache_write_req_valid, m_sq.size() != 0);
      if (m_sq.size() != 0) begin
        checkOutput("write_req_addr", dcache_write_req_addr, m_sq[0].addr);
        checkOutput("write_req_data", dcache_write_req_data, m_sq[0].data);
      end
      checkOutput("protocol_error", protocol_error, m_perr);
      checkOutput("ld_done_valid", ld_done_valid, rhit || m_fwd_valid);
      if (rhit) begin
        e_inv = m_inv[dcache_read_resp_LQ_index] ||
                (dcache_inv_valid && m_addr[dcache_read_resp_LQ_index][13:1] == dcache_inv_block_addr);
        checkOutput("ld_done_idx", ld_done_LQ_index, dcache_read_resp_LQ_index);
        checkOutput("ld_done_data", ld_done_data, dcache_read_resp_data);
        checkOutput("ld_done_inv", ld_done_inv, e_inv);
      end else if (m_fwd_valid) begin
        checkOutput("fwd_done_idx", ld_done_LQ_index, m_fwd_idx);
        checkOutput("fwd_done_data", ld_done_data, m_fwd_data);
        checkOutput("fwd_done_inv", ld_done_inv, 0);
      end
      dup = acc && m_valid[ld_req_LQ_index] && !(rhit && dcache_read_resp_LQ_index == ld_req_LQ_index);
      if (dup || (dcache_read_resp_valid && !rhit)) m_perr = 1;
      for (int i = 0; i < LQ; i++)
        if (dcache_inv_valid && m_valid[i] && m_addr[i][13:1] == dcache_inv_block_addr) m_inv[i] = 1;
      if (rhit) m_valid[dcache_read_resp_LQ_index] = 0;
      if (rd_v) begin
        m_valid[ld_req_LQ_index] = 1;
        m_addr[ld_req_LQ_index]  = ld_req_addr;
        m_inv[ld_req_LQ_index]   = 0;
      end
      if (m_fwd_valid && !rhit) m_fwd_valid = 0;
      if (acc && fhit) begin
        m_fwd_valid = 1;
        m_fwd_idx   = ld_req_LQ_index;
        m_fwd_data  = fdata;
      end
      if (m_sq.size() != 0 && !dcache_write_req_blocked) void'(m_sq.pop_front());
      if (enq) m_sq.push_back({st_commit_addr, st_commit_data});
    end
  end

  initial begin
    stim_t s;
    int    free_q[$];
    int    busy_q[$];
    nRST = 1'b1;
    setInputs('0);
    repeat (2) @(posedge CLK);
    #2;
    checkOutput("reset_sq_empty", sq_empty, 1);
    checkOutput("reset_ld_req_ready", ld_req_ready, 0);
    #1 nRST = 1'b0;

    // Simple load followed by its response.
    s = '0; s.ld_valid = 1; s.ld_idx = 3; s.ld_addr = 14'h0010;
    applyStimulus(s); #1;
    checkOutput("t1_read_valid", dcache_read_req_valid, 1);
    checkOutput("t1_read_addr", dcache_read_req_addr, 14'h0010);
    s = '0; s.resp_valid = 1; s.resp_idx = 3; s.resp_data = 32'hDEADBEEF;
    applyStimulus(s); #1;
    checkOutput("t1_done_valid", ld_done_valid, 1);
    checkOutput("t1_done_idx", ld_done_LQ_index, 3);
    checkOutput("t1_done_data", ld_done_data, 32'hDEADBEEF);
    checkOutput("t1_done_inv", ld_done_inv, 0);

    // Fill the store buffer under backpressure, then drain it.
    for (int k = 0; k < 4; k++) begin
      s = '0; s.st_valid = 1; s.st_addr = 14'h0100 + 14'(k); s.st_data = 32'hA000 + k; s.wr_blocked = 1;
      applyStimulus(s); #1;
      checkOutput("t2_ready_filling", st_commit_ready, 1);
    end
    for (int k = 0; k < 2; k++) begin
      s = '0; s.st_valid = 1; s.st_addr = 14'h0104; s.st_data = 32'hA004; s.wr_blocked = 1;
      applyStimulus(s); #1;
      checkOutput("t2_ready_full", st_commit_ready, 0);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus('0); #1;
      checkOutput("t2_drain_valid", dcache_write_req_valid, 1);
      checkOutput("t2_drain_addr", dcache_write_req_addr, 14'h0100 + 14'(k));
      checkOutput("t2_drain_data", dcache_write_req_data, 32'hA000 + k);
    end
    applyStimulus('0); #1;
    checkOutput("t2_sq_empty", sq_empty, 1);

    // Load to an address with a buffered store.
    s = '0; s.st_valid = 1; s.st_addr = 14'h0020; s.st_data = 32'h12345678; s.wr_blocked = 1;
    applyStimulus(s);
`ifdef STORE_FWD_EN
    s = '0; s.ld_valid = 1; s.ld_idx = 1; s.ld_addr = 14'h0020; s.wr_blocked = 1;
    applyStimulus(s); #1;
    checkOutput("t3_fwd_ready", ld_req_ready, 1);
    checkOutput("t3_fwd_no_read", dcache_read_req_valid, 0);
    s = '0; s.wr_blocked = 1;
    applyStimulus(s); #1;
    checkOutput("t3_fwd_done_valid", ld_done_valid, 1);
    checkOutput("t3_fwd_done_data", ld_done_data, 32'h12345678);
    s = '0; s.ld_valid = 1; s.ld_idx = 1; s.ld_addr = 14'h0044; s.wr_blocked = 1;
    applyStimulus(s);
    s = '0; s.ld_valid = 1; s.ld_idx = 4; s.ld_addr = 14'h0020; s.wr_blocked = 1;
    applyStimulus(s);
    s = '0; s.resp_valid = 1; s.resp_idx = 1; s.resp_data = 32'h11111111; s.wr_blocked = 1;
    applyStimulus(s); #1;
    checkOutput("t6_resp_first_idx", ld_done_LQ_index, 1);
    checkOutput("t6_resp_first_data", ld_done_data, 32'h11111111);
    s = '0; s.wr_blocked = 1;
    applyStimulus(s); #1;
    checkOutput("t6_fwd_second_idx", ld_done_LQ_index, 4);
    checkOutput("t6_fwd_second_data", ld_done_data, 32'h12345678);
    applyStimulus('0);
`else
    for (int k = 0; k < 2; k++) begin
      s = '0; s.ld_valid = 1; s.ld_idx = 1; s.ld_addr = 14'h0020; s.wr_blocked = 1;
      applyStimulus(s); #1;
      checkOutput("t3_stall_ready", ld_req_ready, 0);
      checkOutput("t3_stall_no_read", dcache_read_req_valid, 0);
    end
    s.wr_blocked = 0;
    applyStimulus(s); #1;
    checkOutput("t3_drain_cycle_ready", ld_req_ready, 0);
    applyStimulus(s); #1;
    checkOutput("t3_after_drain_read", dcache_read_req_valid, 1);
    checkOutput("t3_after_drain_addr", dcache_read_req_addr, 14'h0020);
    s = '0; s.resp_valid = 1; s.resp_idx = 1; s.resp_data = 32'h0BADF00D;
    applyStimulus(s);
`endif

    // Invalidation of an in-flight load.
    s = '0; s.ld_valid = 1; s.ld_idx = 5; s.ld_addr = 14'h0042;
    applyStimulus(s);
    s = '0; s.inv_valid = 1; s.inv_blk = 13'h0021;
    applyStimulus(s);
    s = '0; s.resp_valid = 1; s.resp_idx = 5; s.resp_data = 32'h55;
    applyStimulus(s); #1;
    checkOutput("t4_inv_done", ld_done_valid, 1);
    checkOutput("t4_inv_flag", ld_done_inv, 1);

    // Orphan response: dropped and the error is sticky until reset.
    s = '0; s.resp_valid = 1; s.resp_idx = 2; s.resp_data = 32'h22;
    applyStimulus(s); #1;
    checkOutput("t5_orphan_no_done", ld_done_valid, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus('0); #1;
      checkOutput("t5_error_sticky", protocol_error, 1);
    end
    @(posedge CLK); #1 nRST = 1'b1;
    #1 checkOutput("t5_error_cleared", protocol_error, 0);
    @(posedge CLK); #1 nRST = 1'b0;

    // Randomized traffic over a small address window so stores and loads collide often.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK); #1;
      free_q.delete();
      busy_q.delete();
      for (int i = 0; i < LQ; i++) begin
        if (m_valid[i]) busy_q.push_back(i);
        else if (!(m_fwd_valid && m_fwd_idx == 3'(i))) free_q.push_back(i);
      end
      s = '0;
      s.ld_addr = 14'h0200 + 14'($urandom_range(0, 7));
      if (free_q.size() != 0 && $urandom_range(0, 99) < 50) begin
        s.ld_valid = 1;
        s.ld_idx   = 3'(free_q[$urandom_range(0, free_q.size() - 1)]);
      end
      s.st_valid   = ($urandom_range(0, 99) < 30);
      s.st_addr    = 14'h0200 + 14'($urandom_range(0, 7));
      s.st_data    = $urandom;
      s.rd_blocked = ($urandom_range(0, 99) < 15);
      s.wr_blocked = ($urandom_range(0, 99) < 40);
      if (busy_q.size() != 0 && $urandom_range(0, 99) < 50) begin
        s.resp_valid = 1;
        s.resp_idx   = 3'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
        s.resp_data  = $urandom;
      end
      s.inv_valid = ($urandom_range(0, 99) < 15);
      s.inv_blk   = 13'h0100 + 13'($urandom_range(0, 3));
      setInputs(s);
    end

    // Reset mid-traffic; a late response afterwards has no owner.
    @(posedge CLK); #1;
    setInputs('0);
    nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b0;
    s = '0; s.resp_valid = 1; s.resp_idx = 0; s.resp_data = 32'h77;
    applyStimulus(s); #1;
    checkOutput("late_resp_no_done", ld_done_valid, 0);
    applyStimulus('0); #1;
    checkOutput("late_resp_error", protocol_error, 1);

    @(posedge CLK); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
